alu_control: RTL and testbench

ALU_CONTROL -- requirements
Module: alu_control

---
 rtl/alu_control.sv | 114 +++++++++++
 tb/tb_alu_control.sv | 122 ++++++++++++
 2 files changed

// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
// Module      : alu_control
// Description : LEGv8 ALU control decoder. It maps (opcode, ALUOp) to a
//               registered 4-bit ALU control code and an illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic [1:0]  ALUOp,
    output logic [3:0]  ALUCtl,
    output logic        illegal
);

    localparam logic [3:0] c_ctl_and  = 4'b0000;
    localparam logic [3:0] c_ctl_orr  = 4'b0001;
    localparam logic [3:0] c_ctl_add  = 4'b0010;
    localparam logic [3:0] c_ctl_eor  = 4'b0011;
    localparam logic [3:0] c_ctl_sub  = 4'b0110;
    localparam logic [3:0] c_ctl_pass = 4'b0111;
    localparam logic [3:0] c_ctl_lsl  = 4'b1000;
    localparam logic [3:0] c_ctl_lsr  = 4'b1001;
    localparam logic [3:0] c_ctl_inv  = 4'b1111;

    localparam logic [1:0] c_aluop_mem  = 2'b00;
    localparam logic [1:0] c_aluop_cbz  = 2'b01;
    localparam logic [1:0] c_aluop_rtyp = 2'b10;

    logic [3:0] w_r_ctl;
    logic       w_r_hit;
    logic [3:0] w_i_ctl;
    logic       w_i_hit;
    logic [3:0] w_ctl;
    logic       w_illegal;

    logic [3:0] r_ctl;
    logic       r_illegal;

    // R-type: full 11-bit opcode match
    always_comb begin
        w_r_ctl = c_ctl_inv;
        w_r_hit = 1'b1;
        case (opcode)
            11'b10001011000: w_r_ctl = c_ctl_add;
            11'b11001011000: w_r_ctl = c_ctl_sub;
            11'b10001010000: w_r_ctl = c_ctl_and;
            11'b10101010000: w_r_ctl = c_ctl_orr;
            11'b11001010000: w_r_ctl = c_ctl_eor;
            11'b11010011011: w_r_ctl = c_ctl_lsl;
            11'b11010011010: w_r_ctl = c_ctl_lsr;
            default:         w_r_hit = 1'b0;
        endcase
    end

    // I-type: opcode[0] belongs to the immediate field and is ignored
    always_comb begin
        w_i_ctl = c_ctl_inv;
        w_i_hit = 1'b1;
        case (opcode[10:1])
            10'b1001000100: w_i_ctl = c_ctl_add;
            10'b1101000100: w_i_ctl = c_ctl_sub;
            10'b1001001000: w_i_ctl = c_ctl_and;
            10'b1011001000: w_i_ctl = c_ctl_orr;
            10'b1101001000: w_i_ctl = c_ctl_eor;
            default:        w_i_hit = 1'b0;
        endcase
    end

    // Opcode is only consulted for the R/I class, so don't-care bits elsewhere are harmless
    always_comb begin
        w_ctl     = c_ctl_inv;
        w_illegal = 1'b1;
        case (ALUOp)
            c_aluop_mem: begin
                w_ctl     = c_ctl_add;
                w_illegal = 1'b0;
            end
            c_aluop_cbz: begin
                w_ctl     = c_ctl_pass;
                w_illegal = 1'b0;
            end
            c_aluop_rtyp: begin
                if (w_r_hit) begin
                    w_ctl     = w_r_ctl;
                    w_illegal = 1'b0;
                end else if (w_i_hit) begin
                    w_ctl     = w_i_ctl;
                    w_illegal = 1'b0;
                end
            end
            default: begin
                w_ctl     = c_ctl_inv;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctl     <= c_ctl_add;
            r_illegal <= 1'b0;
        end else begin
            r_ctl     <= w_ctl;
            r_illegal <= w_illegal;
        end
    end

    assign ALUCtl  = r_ctl;
    assign illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control
// Description : Self-checking bench for alu_control against a table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control;

    logic        clk;
    logic        reset;
    logic [10:0] opcode;
    logic [1:0]  ALUOp;
    logic [3:0]  ALUCtl;
    logic        illegal;

    int n_compared;
    int n_mismatched;

    logic [10:0] r_ops   [7] = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
                                 11'b10101010000, 11'b11001010000, 11'b11010011011,
                                 11'b11010011010};
    logic [3:0]  r_codes [7] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd3, 4'd8, 4'd9};
    logic [9:0]  i_ops   [5] = '{10'b1001000100, 10'b1101000100, 10'b1001001000,
                                 10'b1011001000, 10'b1101001000};
    logic [3:0]  i_codes [5] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd3};

    alu_control dut (
        .clk     (clk),
        .reset   (reset),
        .opcode  (opcode),
        .ALUOp   (ALUOp),
        .ALUCtl  (ALUCtl),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {ALUCtl, illegal} for one un-reset decode
    function automatic logic [4:0] model(input logic [10:0] op, input logic [1:0] aop);
        if (aop == 2'd0) return {4'd2, 1'b0};
        if (aop == 2'd1) return {4'd7, 1'b0};
        if (aop == 2'd3) return {4'd15, 1'b1};
        for (int k = 0; k < 7; k++)
            if (op == r_ops[k]) return {r_codes[k], 1'b0};
        for (int k = 0; k < 5; k++)
            if (op[10:1] == i_ops[k]) return {i_codes[k], 1'b0};
        return {4'd15, 1'b1};
    endfunction

    task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got ctl=%b ill=%b, want ctl=%b ill=%b",
                     tag, obs[4:1], obs[0], exp[4:1], exp[0]);
        end
    endtask

    // Drive inputs, take one edge, then compare shortly after it
    task automatic step(input string tag, input logic [10:0] op, input logic [1:0] aop,
                        input logic rst);
        logic [4:0] exp;
        opcode = op;
        ALUOp  = aop;
        reset  = rst;
        exp    = rst ? {4'd2, 1'b0} : model(op, aop);
        @(posedge clk);
        #1;
        check_eq(tag, {ALUCtl, illegal}, exp);
    endtask

    initial begin
        logic [10:0] op;
        logic [1:0]  aop;
        n_compared   = 0;
        n_mismatched = 0;
        opcode = '0;
        ALUOp  = 2'd3;
        reset  = 1'b1;

        step("reset0", 11'h7ff, 2'd3, 1'b1);
        step("reset1", 11'h000, 2'd1, 1'b1);

        step("mem_x", 11'bx, 2'd0, 1'b0);
        step("cbz_x", 11'bx, 2'd1, 1'b0);
        step("add",  11'b10001011000, 2'd2, 1'b0);
        step("sub",  11'b11001011000, 2'd2, 1'b0);
        step("and",  11'b10001010000, 2'd2, 1'b0);
        step("orr",  11'b10101010000, 2'd2, 1'b0);
        step("eor",  11'b11001010000, 2'd2, 1'b0);
        step("lsl",  11'b11010011011, 2'd2, 1'b0);
        step("lsr",  11'b11010011010, 2'd2, 1'b0);
        step("addi_b1", 11'b10010001001, 2'd2, 1'b0);
        step("subi_b0", 11'b11010001000, 2'd2, 1'b0);
        step("andi",    11'b10010010001, 2'd2, 1'b0);
        step("orri",    11'b10110010000, 2'd2, 1'b0);
        step("eori",    11'b11010010000, 2'd2, 1'b0);
        step("ones",    11'b11111111111, 2'd2, 1'b0);
        step("zeros",   11'b00000000000, 2'd2, 1'b0);
        step("op11",    11'b10001011000, 2'd3, 1'b0);

        // Reset on the same edge as a SUB, then release with SUB held
        step("rst_sub", 11'b11001011000, 2'd2, 1'b1);
        step("rel_sub", 11'b11001011000, 2'd2, 1'b0);

        for (int n = 0; n < 400; n++) begin
            aop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       op = r_ops[$urandom_range(0, 6)];
                1:       op = {i_ops[$urandom_range(0, 4)], 1'($urandom_range(0, 1))};
                default: op = 11'($urandom);
            endcase
            step("rand", op, aop, ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
